// File: rtl/usb_reset_gen_if.sv
// USB bus-reset generator link/PHY signal bundle plus the line-state type it carries.
// Compile with USB_RESET_GEN_RESUME_EN to add the resume request signal.
package usb_reset_gen_pkg;
  typedef enum logic [1:0] {
    LineSe0 = 2'b00,
    LineJ   = 2'b01,
    LineK   = 2'b10
  } d_port_t;
endpackage

interface usb_reset_gen_if;
  import usb_reset_gen_pkg::*;

  logic    req_i;
  logic    abort_i;
`ifdef USB_RESET_GEN_RESUME_EN
  logic    resume_req_i;
`endif
  d_port_t line_o;
  logic    oe_o;
  logic    busy_o;
  logic    done_o;

`ifdef USB_RESET_GEN_RESUME_EN
  modport master (output req_i, abort_i, resume_req_i, input line_o, oe_o, busy_o, done_o);
  modport slave  (input req_i, abort_i, resume_req_i, output line_o, oe_o, busy_o, done_o);
`else
  modport master (output req_i, abort_i, input line_o, oe_o, busy_o, done_o);
  modport slave  (input req_i, abort_i, output line_o, oe_o, busy_o, done_o);
`endif
endinterface

// File: rtl/usb_reset_gen.sv
// Host/hub-side USB bus reset generator: SE0 for RST_CYCLES, release for RCY_CYCLES, done pulse.
// Optional resume signalling (K, EOP, J) is built when USB_RESET_GEN_RESUME_EN is defined.
module usb_reset_gen
  import usb_reset_gen_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 240000,
  parameter int unsigned RCY_CYCLES = 240000,
`ifdef USB_RESET_GEN_RESUME_EN
  parameter int unsigned RES_CYCLES = 480000,
  parameter int unsigned EOP_CYCLES = 32,
  parameter int unsigned J_CYCLES   = 16,
`endif
  parameter int unsigned CNT_W      = 20
) (
  input logic             clk,
  input logic             reset_i,
  usb_reset_gen_if.slave  bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRst    = 3'd1;
  localparam logic [2:0] StRcy    = 3'd2;
`ifdef USB_RESET_GEN_RESUME_EN
  localparam logic [2:0] StResK   = 3'd3;
  localparam logic [2:0] StResEop = 3'd4;
  localparam logic [2:0] StResJ   = 3'd5;

  localparam logic [CNT_W-1:0] ResLoad = CNT_W'(RES_CYCLES - 1);
  localparam logic [CNT_W-1:0] EopLoad = CNT_W'(EOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] JLoad   = CNT_W'(J_CYCLES - 1);
`endif

  localparam logic [CNT_W-1:0] RstLoad = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RcyLoad = CNT_W'(RCY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_zero = (cnt_q == CntZero);
  // Saturating decrement keeps the counter from wrapping below zero.
  assign cnt_dec  = cnt_zero ? CntZero : cnt_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!bus.abort_i && bus.req_i) begin
          state_d = StRst;
          cnt_d   = RstLoad;
        end
`ifdef USB_RESET_GEN_RESUME_EN
        else if (!bus.abort_i && bus.resume_req_i) begin
          state_d = StResK;
          cnt_d   = ResLoad;
        end
`endif
      end
      StRst: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_zero) begin
          state_d = StRcy;
          cnt_d   = RcyLoad;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StRcy: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
`ifdef USB_RESET_GEN_RESUME_EN
      StResK: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_zero) begin
          state_d = StResEop;
          cnt_d   = EopLoad;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StResEop: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_zero) begin
          state_d = StResJ;
          cnt_d   = JLoad;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StResJ: begin
        if (bus.abort_i) begin
          state_d = StIdle;
          cnt_d   = CntZero;
        end else if (cnt_zero) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        cnt_d   = CntZero;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= CntZero;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs decode only from registered state, so oe_o changes only at transition edges.
  d_port_t line;
  logic    oe;
  logic    busy;

  always_comb begin
    line = LineJ;
    oe   = 1'b0;
    busy = 1'b0;
    case (state_q)
      StRst: begin
        line = LineSe0;
        oe   = 1'b1;
        busy = 1'b1;
      end
      StRcy: busy = 1'b1;
`ifdef USB_RESET_GEN_RESUME_EN
      StResK: begin
        line = LineK;
        oe   = 1'b1;
        busy = 1'b1;
      end
      StResEop: begin
        line = LineSe0;
        oe   = 1'b1;
        busy = 1'b1;
      end
      StResJ: begin
        oe   = 1'b1;
        busy = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.line_o = line;
  assign bus.oe_o   = oe;
  assign bus.busy_o = busy;
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_usb_reset_gen.sv
// Directed bench for usb_reset_gen with RST_CYCLES=8, RCY_CYCLES=4 (resume: 6/2/1).
module tb_usb_reset_gen;
  import usb_reset_gen_pkg::*;

  logic clk = 1'b0;
  logic reset_i;
  int   n_checks = 0;
  int   n_fail = 0;

  usb_reset_gen_if bus ();

  usb_reset_gen #(
    .RST_CYCLES (8),
    .RCY_CYCLES (4),
`ifdef USB_RESET_GEN_RESUME_EN
    .RES_CYCLES (6),
    .EOP_CYCLES (2),
    .J_CYCLES   (1),
`endif
    .CNT_W      (20)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic oe, input d_port_t line,
                       input logic busy, input logic done);
    n_checks++;
    assert (bus.oe_o === oe) else begin
      n_fail++;
      $error("FAIL %s oe_o: got %b want %b", tag, bus.oe_o, oe);
    end
    n_checks++;
    assert (bus.line_o === line) else begin
      n_fail++;
      $error("FAIL %s line_o: got %0d want %0d", tag, bus.line_o, line);
    end
    n_checks++;
    assert (bus.busy_o === busy) else begin
      n_fail++;
      $error("FAIL %s busy_o: got %b want %b", tag, bus.busy_o, busy);
    end
    n_checks++;
    assert (bus.done_o === done) else begin
      n_fail++;
      $error("FAIL %s done_o: got %b want %b", tag, bus.done_o, done);
    end
  endtask

  // Called at the first SE0 sample; ends at the done sample without stepping past it.
  task automatic run_seq(input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_se0"}, 1'b1, LineSe0, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check({tag, "_rcy"}, 1'b0, LineJ, 1'b1, 1'b0);
      step();
    end
    check({tag, "_done"}, 1'b0, LineJ, 1'b0, 1'b1);
  endtask

  initial begin
    reset_i     = 1'b1;
    bus.req_i   = 1'b0;
    bus.abort_i = 1'b0;
`ifdef USB_RESET_GEN_RESUME_EN
    bus.resume_req_i = 1'b0;
`endif
    step();
    step();
    check("reset", 1'b0, LineJ, 1'b0, 1'b0);
    reset_i = 1'b0;
    step();
    check("idle", 1'b0, LineJ, 1'b0, 1'b0);

    // Basic single-cycle request.
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    run_seq("basic");
    step();
    check("basic_after", 1'b0, LineJ, 1'b0, 1'b0);

    // Request held high: ignored mid-sequence, re-accepted in the done cycle.
    bus.req_i = 1'b1;
    step();
    run_seq("held1");
    step();
    run_seq("held2");
    bus.req_i = 1'b0;
    step();
    check("held_after", 1'b0, LineJ, 1'b0, 1'b0);

    // Abort in the third SE0 cycle.
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    check("abort_se0_1", 1'b1, LineSe0, 1'b1, 1'b0);
    step();
    check("abort_se0_2", 1'b1, LineSe0, 1'b1, 1'b0);
    step();
    check("abort_se0_3", 1'b1, LineSe0, 1'b1, 1'b0);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("abort_idle", 1'b0, LineJ, 1'b0, 1'b0);
      step();
    end
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    run_seq("post_abort");
    step();

    // Abort beats request in IDLE.
    bus.req_i   = 1'b1;
    bus.abort_i = 1'b1;
    step();
    check("abort_wins_1", 1'b0, LineJ, 1'b0, 1'b0);
    bus.req_i   = 1'b0;
    bus.abort_i = 1'b0;
    step();
    check("abort_wins_2", 1'b0, LineJ, 1'b0, 1'b0);

    // Synchronous reset in the second recovery cycle.
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("rst_rcy_1", 1'b0, LineJ, 1'b1, 1'b0);
    step();
    check("rst_rcy_2", 1'b0, LineJ, 1'b1, 1'b0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("rst_rcy_reset", 1'b0, LineJ, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_rcy_nodone", 1'b0, LineJ, 1'b0, 1'b0);
    end

    // Reset has priority over a request.
    reset_i   = 1'b1;
    bus.req_i = 1'b1;
    step();
    reset_i   = 1'b0;
    bus.req_i = 1'b0;
    check("rst_over_req", 1'b0, LineJ, 1'b0, 1'b0);

`ifdef USB_RESET_GEN_RESUME_EN
    // Resume: K x6, SE0 x2, J x1 driven, then done.
    bus.resume_req_i = 1'b1;
    step();
    bus.resume_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("res_k", 1'b1, LineK, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      check("res_eop", 1'b1, LineSe0, 1'b1, 1'b0);
      step();
    end
    check("res_j", 1'b1, LineJ, 1'b1, 1'b0);
    step();
    check("res_done", 1'b0, LineJ, 1'b0, 1'b1);
    step();
    check("res_after", 1'b0, LineJ, 1'b0, 1'b0);

    // Bus reset wins over resume.
    bus.req_i        = 1'b1;
    bus.resume_req_i = 1'b1;
    step();
    bus.req_i        = 1'b0;
    bus.resume_req_i = 1'b0;
    run_seq("req_over_res");
    step();

    // Abort during K.
    bus.resume_req_i = 1'b1;
    step();
    bus.resume_req_i = 1'b0;
    check("res_abort_k", 1'b1, LineK, 1'b1, 1'b0);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("res_abort_idle", 1'b0, LineJ, 1'b0, 1'b0);
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
